// File: rtl/serial_fifo_uart.sv
// Full-duplex UART with TX/RX FIFOs, sticky overrun/framing flags and occupancy counts.
// The front end exchanges bytes through valid/ready handshakes; this block owns all bit timing.

module serial_fifo_uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rd,
  output logic [W-1:0]  o_rdata,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_wr;
  logic          w_do_rd;

  // Count only reaches DEPTH when full, so its MSB alone marks the full state.
  assign o_full  = r_count[AW];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A write into a full FIFO is still accepted when a pop frees the head slot this cycle.
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
  end
endmodule

module serial_fifo_uart #(
  parameter int CLK_DIV   = 687,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_pop,
  output logic [FIFO_AW:0]     tx_count,
  output logic [FIFO_AW:0]     rx_count,
  output logic                 tx_busy,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
  input  logic                 clr_err,
  output logic                 txd,
  input  logic                 rxd
);
  localparam int DIVW = $clog2(STOP_BITS * CLK_DIV + 1);
  localparam int BITW = $clog2(DATA_BITS + 1);
  localparam logic [DIVW-1:0] BIT_LAST  = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] STOP_LAST = DIVW'(STOP_BITS * CLK_DIV - 1);
  localparam logic [DIVW-1:0] HALF_LAST = DIVW'(CLK_DIV / 2 - 1);
  localparam logic [BITW-1:0] DATA_LAST = BITW'(DATA_BITS - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic [DATA_BITS-1:0] w_tx_head;
  logic                 w_tx_full;
  logic                 w_tx_empty;
  logic                 w_tx_push;
  logic                 w_tx_pop;
  logic                 w_rx_full;
  logic                 w_rx_empty;

  tx_state_t            r_tx_state;
  logic [DIVW-1:0]      r_tx_cnt;
  logic [BITW-1:0]      r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_txd;
  logic                 r_tx_busy;

  rx_state_t            r_rx_state;
  logic [DIVW-1:0]      r_rx_cnt;
  logic [BITW-1:0]      r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_sync1;
  logic                 r_rx_sync2;
  logic                 r_rx_prev;
  logic                 r_rx_overrun;
  logic                 r_rx_frame_err;

  logic                 w_rx_bit;
  logic                 w_rx_fall;
  logic                 w_rx_stop_hit;
  logic                 w_rx_wr;
  logic                 w_rx_ferr;
  logic                 w_rx_ovr;

  assign w_tx_push = tx_valid && !w_tx_full;
  assign tx_ready  = !w_tx_full;
  assign rx_valid  = !w_rx_empty;

  serial_fifo_uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_wr    (w_tx_push),
    .i_wdata (tx_data),
    .i_rd    (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_count (tx_count),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  serial_fifo_uart_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_wr    (w_rx_wr),
    .i_wdata (r_rx_shift),
    .i_rd    (rx_pop),
    .o_rdata (rx_data),
    .o_count (rx_count),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // The next byte is taken either from idle or on the final stop cycle, giving gapless frames.
  assign w_tx_pop = !w_tx_empty &&
                    ((r_tx_state == TX_IDLE) ||
                     (r_tx_state == TX_STOP && r_tx_cnt == STOP_LAST));

  // txd and tx_busy are registered from the state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_txd     <= 1'b1;
          r_tx_busy <= 1'b0;
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          r_txd     <= 1'b0;
          r_tx_busy <= 1'b1;
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + DIVW'(1);
          end
        end
        TX_DATA: begin
          r_txd     <= r_tx_shift[0];
          r_tx_busy <= 1'b1;
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= r_tx_shift >> 1;
            if (r_tx_bit == DATA_LAST) r_tx_state <= TX_STOP;
            else                       r_tx_bit   <= r_tx_bit + BITW'(1);
          end else begin
            r_tx_cnt <= r_tx_cnt + DIVW'(1);
          end
        end
        TX_STOP: begin
          r_txd     <= 1'b1;
          r_tx_busy <= 1'b1;
          if (r_tx_cnt == STOP_LAST) begin
            r_tx_cnt <= '0;
            if (w_tx_pop) begin
              r_tx_shift <= w_tx_head;
              r_tx_state <= TX_START;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + DIVW'(1);
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign txd     = r_txd;
  assign tx_busy = r_tx_busy;

  assign w_rx_bit      = r_rx_sync2;
  assign w_rx_fall     = r_rx_prev && !r_rx_sync2;
  assign w_rx_stop_hit = (r_rx_state == RX_STOP) && (r_rx_cnt == BIT_LAST);
  assign w_rx_wr       = w_rx_stop_hit && w_rx_bit;
  assign w_rx_ferr     = w_rx_stop_hit && !w_rx_bit;
  assign w_rx_ovr      = w_rx_wr && w_rx_full && !rx_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_sync1 <= rxd;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            // A start bit already high again at mid-bit is treated as line noise.
            r_rx_state <= w_rx_bit ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + DIVW'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx_bit, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bit == DATA_LAST) r_rx_state <= RX_STOP;
            else                       r_rx_bit   <= r_rx_bit + BITW'(1);
          end else begin
            r_rx_cnt <= r_rx_cnt + DIVW'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= w_rx_bit ? RX_IDLE : RX_BREAK;
          end else begin
            r_rx_cnt <= r_rx_cnt + DIVW'(1);
          end
        end
        RX_BREAK: begin
          if (w_rx_bit) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      if (w_rx_ovr)     r_rx_overrun <= 1'b1;
      else if (clr_err) r_rx_overrun <= 1'b0;
      if (w_rx_ferr)    r_rx_frame_err <= 1'b1;
      else if (clr_err) r_rx_frame_err <= 1'b0;
    end
  end

  assign rx_overrun   = r_rx_overrun;
  assign rx_frame_err = r_rx_frame_err;
endmodule

// File: tb/tb_serial_fifo_uart.sv
// Directed bench for serial_fifo_uart: TX framing, loopback, FIFO limits, RX glitch/break, async reset.
// Runs with CLK_DIV=16, 8 data bits, 1 stop bit, depth-4 FIFOs.

module tb_serial_fifo_uart;
  localparam int CLK_DIV   = 16;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int FIFO_AW   = 2;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic [2:0] tx_count;
  logic [2:0] rx_count;
  logic       tx_busy;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       clr_err;
  logic       txd;
  logic       rxd;
  logic       tb_rxd;
  logic       loop_en;

  int n_checks = 0;
  int n_fail   = 0;

  assign rxd = loop_en ? txd : tb_rxd;

  serial_fifo_uart #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .FIFO_AW(FIFO_AW)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop), .tx_count(tx_count),
    .rx_count(rx_count), .tx_busy(tx_busy), .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err), .clr_err(clr_err), .txd(txd), .rxd(rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check_val(tag, 32'(rx_data), 32'(exp));
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    tb_rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_rxd = d[i];
      repeat (16) @(negedge clk);
    end
    tb_rxd = stop_bit;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "simulation time limit");
  end

  logic       s_txd  [0:170];
  logic       s_busy [0:170];
  logic [7:0] pat;
  logic [15:0] vec;
  logic [7:0] rx_q [$];
  int nb, first_b, last_b, k;

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_pop = 1'b0;
    clr_err = 1'b0; tb_rxd = 1'b1; loop_en = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_val("rst_tx_busy", 32'(tx_busy), 32'd0);
    check_val("rst_txd", 32'(txd), 32'd1);
    check_val("rst_tx_count", 32'(tx_count), 32'd0);
    check_val("rst_rx_count", 32'(rx_count), 32'd0);
    check_val("rst_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single 0xA5 frame: sample j is taken after the j-th edge following the push edge.
    pat = 8'hA5;
    push(pat);
    for (int j = 1; j <= 170; j++) begin
      @(negedge clk);
      s_txd[j]  = txd;
      s_busy[j] = tx_busy;
    end
    check_val("a5_txd_edge1", 32'(s_txd[1]), 32'd1);
    check_val("a5_busy_edge1", 32'(s_busy[1]), 32'd0);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 16; c++) vec[c] = s_txd[2 + 16*b + c];
      if (b == 0)      check_val($sformatf("a5_bit%0d", b), 32'(vec), 32'h0000);
      else if (b == 9) check_val($sformatf("a5_bit%0d", b), 32'(vec), 32'hFFFF);
      else             check_val($sformatf("a5_bit%0d", b), 32'(vec), pat[b-1] ? 32'hFFFF : 32'h0000);
    end
    nb = 0;
    for (int j = 2; j <= 161; j++) if (s_busy[j]) nb++;
    check_val("a5_busy_cycles", 32'(nb), 32'd160);
    check_val("a5_txd_after", 32'(s_txd[162]), 32'd1);
    check_val("a5_busy_after", 32'(s_busy[162]), 32'd0);

    // Loopback, three pushes on consecutive edges; frames must run without a gap.
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h00;
    nb = 0; first_b = -1; last_b = -1;
    for (int j = 1; j <= 600; j++) begin
      @(negedge clk);
      if (j == 1) tx_data = 8'hFF;
      if (j == 2) tx_data = 8'h3C;
      if (j == 3) tx_valid = 1'b0;
      if (tx_busy) begin
        nb++;
        if (first_b < 0) first_b = j;
        last_b = j;
      end
    end
    check_val("lb_busy_cycles", 32'(nb), 32'd480);
    check_val("lb_busy_span", 32'(last_b - first_b + 1), 32'd480);
    repeat (40) @(negedge clk);
    check_val("lb_rx_count", 32'(rx_count), 32'd3);
    pop_check("lb_head0", 8'h00);
    pop_check("lb_head1", 8'hFF);
    pop_check("lb_head2", 8'h3C);
    check_val("lb_rx_valid", 32'(rx_valid), 32'd0);
    check_val("lb_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);

    // Five received bytes into a depth-4 RX FIFO without popping.
    loop_en = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 1; i <= 4; i++) send_rx(8'(i), 1'b1);
    repeat (20) @(negedge clk);
    check_val("ovr_count4", 32'(rx_count), 32'd4);
    check_val("ovr_before", 32'(rx_overrun), 32'd0);
    send_rx(8'h05, 1'b1);
    repeat (20) @(negedge clk);
    check_val("ovr_count_full", 32'(rx_count), 32'd4);
    check_val("ovr_flag", 32'(rx_overrun), 32'd1);
    check_val("ovr_ferr", 32'(rx_frame_err), 32'd0);
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_head%0d", i), 8'(i));
    check_val("ovr_empty", 32'(rx_valid), 32'd0);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check_val("ovr_cleared", 32'(rx_overrun), 32'd0);

    // TX FIFO fills to 4 behind a busy frame; a 5th push is ignored.
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    push(8'h11);
    k = 0;
    while (!tx_busy && k < 50) begin @(negedge clk); k++; end
    check_val("full_busy_start", 32'(tx_busy), 32'd1);
    for (int i = 0; i < 4; i++) push(8'hB1 + 8'(i));
    check_val("full_tx_count", 32'(tx_count), 32'd4);
    check_val("full_tx_ready", 32'(tx_ready), 32'd0);
    push(8'hB5);
    check_val("full_ignored", 32'(tx_count), 32'd4);
    rx_q.delete();
    for (int j = 0; j < 1000; j++) begin
      @(negedge clk);
      rx_pop = 1'b0;
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        rx_pop = 1'b1;
      end
    end
    rx_pop = 1'b0;
    check_val("full_frames", 32'(rx_q.size()), 32'd5);
    check_val("full_rx0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'h11);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("full_rx%0d", i + 1),
                (rx_q.size() > i + 1) ? 32'(rx_q[i+1]) : 32'hFFFF_FFFF, 32'hB1 + 32'(i));

    // Short low glitch on rxd must be rejected silently.
    loop_en = 1'b0;
    repeat (10) @(negedge clk);
    tb_rxd = 1'b0;
    repeat (6) @(negedge clk);
    tb_rxd = 1'b1;
    repeat (60) @(negedge clk);
    check_val("glitch_rx_count", 32'(rx_count), 32'd0);
    check_val("glitch_ferr", 32'(rx_frame_err), 32'd0);

    // Bad stop bit followed by a held-low line: one error, nothing stored.
    send_rx(8'h77, 1'b0);
    repeat (30) @(negedge clk);
    check_val("brk_ferr", 32'(rx_frame_err), 32'd1);
    check_val("brk_rx_count", 32'(rx_count), 32'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    repeat (70) @(negedge clk);
    check_val("brk_no_repeat", 32'(rx_frame_err), 32'd0);
    check_val("brk_rx_count2", 32'(rx_count), 32'd0);
    tb_rxd = 1'b1;
    repeat (40) @(negedge clk);
    send_rx(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check_val("brk_recover_count", 32'(rx_count), 32'd1);
    check_val("brk_recover_data", 32'(rx_data), 32'h5A);
    check_val("brk_recover_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);

    // Asynchronous reset in the middle of a TX data bit and an RX frame.
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    push(8'hC3);
    push(8'h99);
    repeat (56) @(negedge clk);
    check_val("mid_txd_low", 32'(txd), 32'd0);
    check_val("mid_tx_count", 32'(tx_count), 32'd1);
    check_val("mid_rx_count", 32'(rx_count), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_txd", 32'(txd), 32'd1);
    check_val("arst_tx_count", 32'(tx_count), 32'd0);
    check_val("arst_rx_count", 32'(rx_count), 32'd0);
    check_val("arst_rx_valid", 32'(rx_valid), 32'd0);
    check_val("arst_tx_busy", 32'(tx_busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    push(8'h96);
    repeat (200) @(negedge clk);
    check_val("post_rst_count", 32'(rx_count), 32'd1);
    check_val("post_rst_data", 32'(rx_data), 32'h96);
    check_val("post_rst_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
